// File: rtl/axis_concat_skid.sv
// AXI-Stream side-channel packer with a 2-entry registered skid buffer.
// Selected sideband fields (LAST, KEEP, DEST, ID, USER) are folded into the
// LSBs of an extended TDATA word. The remaining channels pass through or are
// driven to their default values. All right_* outputs and left_TREADY come
// directly from flops.
module axis_concat_skid #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned IN_ENABLE_KEEP  = 0,
    parameter int unsigned OUT_ENABLE_KEEP = 0,
    parameter int unsigned IN_ENABLE_LAST  = 1,
    parameter int unsigned OUT_ENABLE_LAST = 0,
    parameter int unsigned IN_ENABLE_DEST  = 0,
    parameter int unsigned OUT_ENABLE_DEST = 0,
    parameter int unsigned DEST_WIDTH      = 16,
    parameter int unsigned IN_ENABLE_ID    = 0,
    parameter int unsigned OUT_ENABLE_ID   = 0,
    parameter int unsigned ID_WIDTH        = 16,
    parameter int unsigned IN_ENABLE_USER  = 0,
    parameter int unsigned OUT_ENABLE_USER = 0,
    parameter int unsigned USER_WIDTH      = 16,
    // Derived widths; a disabled channel collapses to width 1
    localparam int unsigned KW          = (DATA_WIDTH + 7) / 8,
    localparam int unsigned LeftKeepW   = (IN_ENABLE_KEEP != 0) ? KW : 1,
    localparam int unsigned LeftDestW   = (IN_ENABLE_DEST != 0) ? DEST_WIDTH : 1,
    localparam int unsigned LeftIdW     = (IN_ENABLE_ID != 0) ? ID_WIDTH : 1,
    localparam int unsigned LeftUserW   = (IN_ENABLE_USER != 0) ? USER_WIDTH : 1,
    localparam int unsigned RightKeepW  = (OUT_ENABLE_KEEP != 0) ? KW : 1,
    localparam int unsigned RightDestW  = (OUT_ENABLE_DEST != 0) ? DEST_WIDTH : 1,
    localparam int unsigned RightIdW    = (OUT_ENABLE_ID != 0) ? ID_WIDTH : 1,
    localparam int unsigned RightUserW  = (OUT_ENABLE_USER != 0) ? USER_WIDTH : 1,
    localparam int unsigned PackLastW   = (IN_ENABLE_LAST != 0 && OUT_ENABLE_LAST == 0) ? 1 : 0,
    localparam int unsigned PackKeepW   = (IN_ENABLE_KEEP != 0 && OUT_ENABLE_KEEP == 0) ? KW : 0,
    localparam int unsigned PackDestW   = (IN_ENABLE_DEST != 0 && OUT_ENABLE_DEST == 0) ? DEST_WIDTH : 0,
    localparam int unsigned PackIdW     = (IN_ENABLE_ID != 0 && OUT_ENABLE_ID == 0) ? ID_WIDTH : 0,
    localparam int unsigned PackUserW   = (IN_ENABLE_USER != 0 && OUT_ENABLE_USER == 0) ? USER_WIDTH : 0,
    localparam int unsigned TW          = DATA_WIDTH + PackLastW + PackKeepW + PackDestW
                                          + PackIdW + PackUserW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] left_TDATA,
    input  logic                  left_TVALID,
    output logic                  left_TREADY,
    input  logic                  left_TLAST,
    input  logic [LeftKeepW-1:0]  left_TKEEP,
    input  logic [LeftDestW-1:0]  left_TDEST,
    input  logic [LeftIdW-1:0]    left_TID,
    input  logic [LeftUserW-1:0]  left_TUSER,
    output logic [TW-1:0]         right_TDATA,
    output logic                  right_TVALID,
    input  logic                  right_TREADY,
    output logic                  right_TLAST,
    output logic [RightKeepW-1:0] right_TKEEP,
    output logic [RightDestW-1:0] right_TDEST,
    output logic [RightIdW-1:0]   right_TID,
    output logic [RightUserW-1:0] right_TUSER
);

    localparam int unsigned BeatW = TW + 1 + RightKeepW + RightDestW + RightIdW + RightUserW;

    typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

    state_e           state_q;
    logic [BeatW-1:0] m_q, s_q, in_beat;
    logic             left_ready_q, right_valid_q;
    logic             in_acc, out_acc;

    logic [TW-1:0]         packed_data;
    logic                  last_side;
    logic [RightKeepW-1:0] keep_side;
    logic [RightDestW-1:0] dest_side;
    logic [RightIdW-1:0]   id_side;
    logic [RightUserW-1:0] user_side;

    // Build the outgoing beat: packed TDATA (DATA at MSBs, USER at LSBs) plus sidebands
    always_comb begin
        packed_data = TW'(left_TDATA);
        if (PackLastW != 0) packed_data = (packed_data << 1) | TW'(left_TLAST);
        if (PackKeepW != 0) packed_data = (packed_data << KW) | TW'(left_TKEEP);
        if (PackDestW != 0) packed_data = (packed_data << DEST_WIDTH) | TW'(left_TDEST);
        if (PackIdW != 0)   packed_data = (packed_data << ID_WIDTH) | TW'(left_TID);
        if (PackUserW != 0) packed_data = (packed_data << USER_WIDTH) | TW'(left_TUSER);

        last_side = (OUT_ENABLE_LAST != 0) ? ((IN_ENABLE_LAST != 0) ? left_TLAST : 1'b1) : 1'b0;
        keep_side = (OUT_ENABLE_KEEP != 0) ?
                    ((IN_ENABLE_KEEP != 0) ? RightKeepW'(left_TKEEP) : '1) : '0;
        dest_side = (OUT_ENABLE_DEST != 0 && IN_ENABLE_DEST != 0) ? RightDestW'(left_TDEST) : '0;
        id_side   = (OUT_ENABLE_ID != 0 && IN_ENABLE_ID != 0) ? RightIdW'(left_TID) : '0;
        user_side = (OUT_ENABLE_USER != 0 && IN_ENABLE_USER != 0) ? RightUserW'(left_TUSER) : '0;

        in_beat = {packed_data, last_side, keep_side, dest_side, id_side, user_side};
    end

    assign in_acc  = left_TVALID & left_ready_q;
    assign out_acc = right_valid_q & right_TREADY;

    // Skid-buffer FSM; ready/valid are registered so right_TREADY never reaches left_TREADY
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StEmpty;
            left_ready_q  <= 1'b0;
            right_valid_q <= 1'b0;
            m_q           <= '0;
            s_q           <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    // Also raises ready on the first cycle out of reset
                    left_ready_q <= 1'b1;
                    if (in_acc) begin
                        m_q           <= in_beat;
                        right_valid_q <= 1'b1;
                        state_q       <= StBusy;
                    end
                end
                StBusy: begin
                    if (in_acc && out_acc) begin
                        m_q <= in_beat;
                    end else if (in_acc) begin
                        s_q          <= in_beat;
                        left_ready_q <= 1'b0;
                        state_q      <= StFull;
                    end else if (out_acc) begin
                        right_valid_q <= 1'b0;
                        state_q       <= StEmpty;
                    end
                end
                StFull: begin
                    if (out_acc) begin
                        m_q          <= s_q;
                        left_ready_q <= 1'b1;
                        state_q      <= StBusy;
                    end
                end
                default: begin
                    state_q       <= StEmpty;
                    left_ready_q  <= 1'b0;
                    right_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign left_TREADY  = left_ready_q;
    assign right_TVALID = right_valid_q;
    assign {right_TDATA, right_TLAST, right_TKEEP, right_TDEST, right_TID, right_TUSER} = m_q;

endmodule

// File: tb/tb_axis_concat_skid.sv
// Directed bench for axis_concat_skid: default LAST packing, all-packed and
// pass-through/default configurations, backpressure, throughput and reset.
module tb_axis_concat_skid;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- default configuration (LAST packed, 33-bit TDATA)
    logic [31:0] d_ld = '0;
    logic        d_lv = 1'b0, d_ll = 1'b0, d_rr = 1'b0;
    logic        d_lr, d_rv, d_rlast, d_rkeep, d_rdest, d_rid, d_ruser;
    logic [32:0] d_rdata;

    axis_concat_skid u_def (
        .clk(clk), .rst(rst),
        .left_TDATA(d_ld), .left_TVALID(d_lv), .left_TREADY(d_lr), .left_TLAST(d_ll),
        .left_TKEEP(1'b0), .left_TDEST(1'b0), .left_TID(1'b0), .left_TUSER(1'b0),
        .right_TDATA(d_rdata), .right_TVALID(d_rv), .right_TREADY(d_rr),
        .right_TLAST(d_rlast), .right_TKEEP(d_rkeep), .right_TDEST(d_rdest),
        .right_TID(d_rid), .right_TUSER(d_ruser)
    );

    // ---------------- everything packed (46-bit TDATA)
    logic [31:0] p_ld = '0;
    logic        p_lv = 1'b0, p_ll = 1'b0, p_rr = 1'b0;
    logic [3:0]  p_keep = '0, p_dest = '0;
    logic [1:0]  p_id = '0;
    logic [2:0]  p_user = '0;
    logic        p_lr, p_rv, p_rlast, p_rkeep, p_rdest, p_rid, p_ruser;
    logic [45:0] p_rdata;

    axis_concat_skid #(
        .IN_ENABLE_KEEP(1), .IN_ENABLE_DEST(1), .DEST_WIDTH(4),
        .IN_ENABLE_ID(1), .ID_WIDTH(2), .IN_ENABLE_USER(1), .USER_WIDTH(3)
    ) u_pk (
        .clk(clk), .rst(rst),
        .left_TDATA(p_ld), .left_TVALID(p_lv), .left_TREADY(p_lr), .left_TLAST(p_ll),
        .left_TKEEP(p_keep), .left_TDEST(p_dest), .left_TID(p_id), .left_TUSER(p_user),
        .right_TDATA(p_rdata), .right_TVALID(p_rv), .right_TREADY(p_rr),
        .right_TLAST(p_rlast), .right_TKEEP(p_rkeep), .right_TDEST(p_rdest),
        .right_TID(p_rid), .right_TUSER(p_ruser)
    );

    // ---------------- DEST pass-through, KEEP default
    logic [31:0] t_ld = '0;
    logic        t_lv = 1'b0, t_ll = 1'b0, t_rr = 1'b0;
    logic [15:0] t_dest = '0;
    logic        t_lr, t_rv, t_rlast, t_rid, t_ruser;
    logic [3:0]  t_rkeep;
    logic [15:0] t_rdest;
    logic [32:0] t_rdata;

    axis_concat_skid #(
        .OUT_ENABLE_KEEP(1), .IN_ENABLE_DEST(1), .OUT_ENABLE_DEST(1), .DEST_WIDTH(16)
    ) u_pt (
        .clk(clk), .rst(rst),
        .left_TDATA(t_ld), .left_TVALID(t_lv), .left_TREADY(t_lr), .left_TLAST(t_ll),
        .left_TKEEP(1'b0), .left_TDEST(t_dest), .left_TID(1'b0), .left_TUSER(1'b0),
        .right_TDATA(t_rdata), .right_TVALID(t_rv), .right_TREADY(t_rr),
        .right_TLAST(t_rlast), .right_TKEEP(t_rkeep), .right_TDEST(t_rdest),
        .right_TID(t_rid), .right_TUSER(t_ruser)
    );

    typedef struct {
        logic        lv;
        logic [31:0] d;
        logic        l;
        logic        rr;
        logic        erv;
        logic        elr;
        logic [32:0] edata;
        logic        cd;
    } vec_t;

    vec_t vecs[8];
    bit   pat[4];

    initial begin
        logic [45:0] pk_exp;
        logic        pre_lr, pre_rv;
        logic [32:0] pre_data;
        int          sent, recv, cyc, occ;

        // Hand-computed cycle vectors starting from EMPTY with ready high
        vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 33'h1BD5B7DDF, 1'b1};
        vecs[1] = '{1'b1, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 33'h1BD5B7DDF, 1'b1};
        vecs[2] = '{1'b1, 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b0, 33'h1BD5B7DDF, 1'b1};
        vecs[3] = '{1'b1, 32'h00000002, 1'b0, 1'b1, 1'b1, 1'b1, 33'h000000002, 1'b1};
        vecs[4] = '{1'b1, 32'h00000002, 1'b1, 1'b1, 1'b1, 1'b1, 33'h000000005, 1'b1};
        vecs[5] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 33'h000000005, 1'b1};
        vecs[6] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 33'h000000000, 1'b0};
        vecs[7] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 33'h000000000, 1'b0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        pk_exp = {32'h01234567, 1'b0, 4'hF, 4'hA, 2'h1, 3'h5};

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_def_valid", 64'(d_rv), 64'd0);
        chk("rst_def_ready", 64'(d_lr), 64'd0);
        chk("rst_def_data", 64'(d_rdata), 64'd0);
        chk("rst_pk_data", 64'(p_rdata), 64'd0);
        chk("rst_pt_dest", 64'(t_rdest), 64'd0);
        chk("rst_pt_keep", 64'(t_rkeep), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(d_lr), 64'd1);
        chk("post_rst_valid", 64'(d_rv), 64'd0);

        // ---- table-driven vectors on the default instance
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d_lv = vecs[i].lv; d_ld = vecs[i].d; d_ll = vecs[i].l; d_rr = vecs[i].rr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 64'(d_rv), 64'(vecs[i].erv));
            chk($sformatf("vec%0d_ready", i), 64'(d_lr), 64'(vecs[i].elr));
            if (vecs[i].cd) chk($sformatf("vec%0d_data", i), 64'(d_rdata), 64'(vecs[i].edata));
        end

        // ---- all-packed and pass-through instances, one beat each
        @(negedge clk);
        p_lv = 1'b1; p_ld = 32'h01234567; p_ll = 1'b0; p_keep = 4'hF;
        p_dest = 4'hA; p_id = 2'h1; p_user = 3'h5; p_rr = 1'b1;
        t_lv = 1'b1; t_ld = 32'hCAFEF00D; t_ll = 1'b1; t_dest = 16'h1234; t_rr = 1'b1;
        @(posedge clk);
        #1;
        chk("pk_valid", 64'(p_rv), 64'd1);
        chk("pk_data", 64'(p_rdata), 64'(pk_exp));
        chk("pt_valid", 64'(t_rv), 64'd1);
        chk("pt_data", 64'(t_rdata), 64'({32'hCAFEF00D, 1'b1}));
        chk("pt_dest", 64'(t_rdest), 64'h1234);
        chk("pt_keep", 64'(t_rkeep), 64'hF);
        chk("pt_last_unused", 64'(t_rlast), 64'd0);
        @(negedge clk);
        p_lv = 1'b0; t_lv = 1'b0;
        @(posedge clk);
        #1;
        chk("pk_drain", 64'(p_rv), 64'd0);
        chk("pt_drain", 64'(t_rv), 64'd0);

        // ---- backpressure: beats 0..7, ready pattern 1,0,0,1
        sent = 0; recv = 0; cyc = 0;
        while (recv < 8 && cyc < 60) begin
            @(negedge clk);
            d_lv = (sent < 8); d_ld = 32'(sent); d_ll = (sent == 7); d_rr = pat[cyc % 4];
            pre_lr = d_lr; pre_rv = d_rv; pre_data = d_rdata;
            @(posedge clk);
            #1;
            if (pre_rv && d_rr) begin
                chk("bp_order", 64'(pre_data), 64'({32'(recv), recv == 7}));
                recv++;
            end
            if (d_lv && pre_lr) sent++;
            if (pre_rv && !d_rr) begin
                chk("bp_stall_valid", 64'(d_rv), 64'd1);
                chk("bp_stall_data", 64'(d_rdata), 64'(pre_data));
            end
            occ = sent - recv;
            chk("bp_ready", 64'(d_lr), 64'(occ < 2));
            chk("bp_valid", 64'(d_rv), 64'(occ > 0));
            cyc++;
        end
        chk("bp_count", 64'(recv), 64'd8);

        // ---- full throughput: 100 back-to-back beats
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            d_lv = 1'b1; d_ld = 32'(i + 100); d_ll = i[0]; d_rr = 1'b1;
            @(posedge clk);
            #1;
            chk("tp_valid", 64'(d_rv), 64'd1);
            chk("tp_ready", 64'(d_lr), 64'd1);
            chk("tp_data", 64'(d_rdata), 64'({32'(i + 100), i[0]}));
        end
        @(negedge clk);
        d_lv = 1'b0;
        @(posedge clk);
        #1;
        chk("tp_drain", 64'(d_rv), 64'd0);

        // ---- reset while FULL
        @(negedge clk);
        d_lv = 1'b1; d_ld = 32'hA; d_rr = 1'b0;
        @(negedge clk);
        d_ld = 32'hB;
        @(posedge clk);
        #1;
        chk("full_ready", 64'(d_lr), 64'd0);
        @(negedge clk);
        rst = 1'b1; d_lv = 1'b0;
        @(posedge clk);
        #1;
        chk("rfull_valid", 64'(d_rv), 64'd0);
        chk("rfull_ready", 64'(d_lr), 64'd0);
        chk("rfull_data", 64'(d_rdata), 64'd0);
        @(negedge clk);
        rst = 1'b0; d_rr = 1'b1;
        @(posedge clk);
        #1;
        chk("rfull_ready_rise", 64'(d_lr), 64'd1);
        chk("rfull_valid_low", 64'(d_rv), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rfull_no_stale", 64'(d_rv), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
